// File: rtl/filter_pkg.sv
// Shared types and the saturating clamp used by every filter lane.
package filter_pkg;

    typedef enum logic [1:0] {
        MODE_MAC = 2'd0,
        MODE_MAX = 2'd1,
        MODE_MIN = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    // Clamp a signed value into the unsigned range [0, 2^dw - 1].
    function automatic logic [63:0] sat_clamp(input logic signed [63:0] v, input int unsigned dw);
        logic signed [63:0] maxv;
        maxv = (64'sd1 <<< dw) - 64'sd1;
        if (v < 64'sd0)
            return '0;
        if (v > maxv)
            return maxv;
        return v;
    endfunction

endpackage

// File: rtl/filter_lane.sv
// One pixel lane: signed multiply-accumulate or unsigned max/min, with the final
// result shifted, clamped and registered when the last tap of a window arrives.
module filter_lane
    import filter_pkg::*;
#(
    parameter int DW   = 18,
    parameter int CW   = 8,
    parameter int TAPS = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 init_i,
    input  logic                 final_i,
    input  logic [1:0]           mode_i,
    input  logic [4:0]           shift_i,
    input  logic signed [CW-1:0] coef_i,
    input  logic [DW-1:0]        pix_i,
    output logic [DW-1:0]        res_o
);

    localparam int AW = DW + CW + 1 + $clog2(TAPS);
    localparam int PW = DW + CW + 1;

    logic signed [AW-1:0] acc_q, acc_d, shifted;
    logic signed [DW:0]   pix_s;
    logic signed [PW-1:0] prod;
    logic [DW-1:0]        res_q, res_d, cur;
    mode_e                mode;

    always_comb begin
        mode    = mode_e'(mode_i);
        pix_s   = {1'b0, pix_i};
        prod    = PW'(pix_s) * PW'(coef_i);
        cur     = acc_q[DW-1:0];
        // Max/min reuse the accumulator's low bits as the running extreme.
        case (mode)
            MODE_MAX: acc_d = (init_i || pix_i > cur) ? AW'(pix_i) : acc_q;
            MODE_MIN: acc_d = (init_i || pix_i < cur) ? AW'(pix_i) : acc_q;
            default:  acc_d = init_i ? AW'(prod) : acc_q + AW'(prod);
        endcase
        shifted = acc_d >>> shift_i;
        if (mode == MODE_MAX || mode == MODE_MIN)
            res_d = acc_d[DW-1:0];
        else
            res_d = DW'(sat_clamp(64'(shifted), DW));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            if (load_i)
                acc_q <= acc_d;
            if (final_i)
                res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/simd_filter_engine.sv
// Multi-lane filter engine: window FSM, tap counter, coefficient file and
// valid/ready handshakes around LANES independent filter_lane datapaths.
module simd_filter_engine
    import filter_pkg::*;
#(
    parameter int LANES = 3,
    parameter int DW    = 18,
    parameter int TAPS  = 9,
    parameter int CW    = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic [4:0]                 shift,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [CW-1:0]              coef_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0][DW-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0][DW-1:0]   out_data,
    output logic                       busy
);

    localparam int TW = $clog2(TAPS);

    state_e          state_q;
    logic [TW-1:0]   tap_q;
    logic [1:0]      mode_q;
    logic [4:0]      shift_q;
    logic [CW-1:0]   coef_q [TAPS];
    logic            out_valid_q;

    logic            accept, is_idle, last;
    logic [1:0]      mode_sel;
    logic [4:0]      shift_sel;
    logic [CW-1:0]   coef_sel;

    assign is_idle   = (state_q == IDLE);
    assign in_ready  = (state_q != OUT);
    assign busy      = !is_idle;
    assign out_valid = out_valid_q;
    assign accept    = in_valid && in_ready && !clr;
    assign last      = (state_q == ACCUM) && (tap_q == TW'(TAPS - 1));
    // Tap 0 arrives before mode/shift are latched, so take them straight from the ports.
    assign mode_sel  = is_idle ? mode  : mode_q;
    assign shift_sel = is_idle ? shift : shift_q;
    assign coef_sel  = coef_q[tap_q];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    mode_q  <= mode;
                    shift_q <= shift;
                    tap_q   <= TW'(1);
                    state_q <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    if (last) begin
                        tap_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        tap_q <= tap_q + TW'(1);
                    end
                end
                OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < TAPS; i++)
                coef_q[i] <= '0;
        end else if (coef_we && is_idle && (int'(coef_addr) < TAPS)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        filter_lane #(
            .DW   (DW),
            .CW   (CW),
            .TAPS (TAPS)
        ) u_lane (
            .clk_i   (CLK),
            .rst_ni  (RST),
            .load_i  (accept),
            .init_i  (is_idle),
            .final_i (accept && last),
            .mode_i  (mode_sel),
            .shift_i (shift_sel),
            .coef_i  (coef_sel),
            .pix_i   (in_data[l]),
            .res_o   (out_data[l])
        );
    end

endmodule

// File: tb/tb_simd_filter_engine.sv
// Directed bench for simd_filter_engine with hand-computed expected results.
module tb_simd_filter_engine;

    localparam int LANES = 3;
    localparam int DW    = 18;
    localparam int TAPS  = 9;
    localparam int CW    = 8;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic                     clr;
    logic [1:0]               mode;
    logic [4:0]               shift;
    logic                     coef_we;
    logic [3:0]               coef_addr;
    logic [CW-1:0]            coef_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0][DW-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0][DW-1:0] out_data;
    logic                     busy;

    int total = 0;
    int fails = 0;
    int seq [9] = '{3, 7, 1, 200, 9, 4, 4, 50, 2};

    simd_filter_engine #(
        .LANES (LANES),
        .DW    (DW),
        .TAPS  (TAPS),
        .CW    (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .mode      (mode),
        .shift     (shift),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        in_valid   = 1'b1;
        in_data[0] = a;
        in_data[1] = b;
        in_data[2] = c;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic set_coefs(input logic [CW-1:0] v);
        for (int i = 0; i < TAPS; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = v;
            step();
        end
        coef_we = 1'b0;
    endtask

    task automatic window(input logic [1:0] m, input logic [4:0] s,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        mode  = m;
        shift = s;
        for (int i = 0; i < TAPS; i++)
            send(a, b, c);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b0; clr = 1'b0; mode = 2'd0; shift = 5'd0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        step();

        // Box filter with saturation on lane 1
        set_coefs(8'd1);
        mode = 2'd0; shift = 5'd0;
        for (int i = 0; i < TAPS - 1; i++)
            send(18'd10, 18'd262143, 18'd0);
        chk("box_no_early_valid", 64'(out_valid), 64'd0);
        chk("box_busy", 64'(busy), 64'd1);
        send(18'd10, 18'd262143, 18'd0);
        chk("box_valid", 64'(out_valid), 64'd1);
        chk("box_lane0", 64'(out_data[0]), 64'd90);
        chk("box_lane1_sat", 64'(out_data[1]), 64'd262143);
        chk("box_lane2", 64'(out_data[2]), 64'd0);
        drain();
        chk("box_in_ready_after", 64'(in_ready), 64'd1);
        chk("box_valid_after", 64'(out_valid), 64'd0);

        // Negative result clamps to zero
        set_coefs(8'hFF);
        window(2'd0, 5'd0, 18'd5, 18'd5, 18'd5);
        chk("neg_valid", 64'(out_valid), 64'd1);
        chk("neg_clamp", 64'(out_data), 64'd0);
        drain();

        // Arithmetic shift
        set_coefs(8'd1);
        window(2'd0, 5'd3, 18'd8, 18'd8, 18'd8);
        chk("shift_lane0", 64'(out_data[0]), 64'd9);
        chk("shift_lane2", 64'(out_data[2]), 64'd9);
        drain();

        // MAX / MIN ignore coefficients and shift
        set_coefs(8'd3);
        mode = 2'd1; shift = 5'd7;
        for (int i = 0; i < TAPS; i++)
            send(18'(seq[i]), 18'd5, 18'd0);
        chk("max_lane0", 64'(out_data[0]), 64'd200);
        chk("max_lane1", 64'(out_data[1]), 64'd5);
        drain();
        mode = 2'd2;
        for (int i = 0; i < TAPS; i++)
            send(18'(seq[i]), 18'd5, 18'd0);
        chk("min_lane0", 64'(out_data[0]), 64'd1);
        chk("min_lane1", 64'(out_data[1]), 64'd5);
        drain();

        // Input gaps mid-window, then output backpressure
        set_coefs(8'd1);
        mode = 2'd0; shift = 5'd0;
        for (int i = 0; i < 4; i++)
            send(18'd10, 18'd20, 18'd30);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_busy", 64'(busy), 64'd1);
            chk("gap_no_valid", 64'(out_valid), 64'd0);
        end
        for (int i = 0; i < 5; i++)
            send(18'd10, 18'd20, 18'd30);
        chk("gap_lane0", 64'(out_data[0]), 64'd90);
        chk("gap_lane2", 64'(out_data[2]), 64'd270);
        in_valid = 1'b1;
        in_data  = {18'd999, 18'd999, 18'd999};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data[0]), 64'd90);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_busy_after", 64'(busy), 64'd0);

        // Abort after 4 taps; clr also wins over a simultaneous accept
        mode = 2'd0;
        for (int i = 0; i < 4; i++)
            send(18'd100, 18'd100, 18'd100);
        clr = 1'b1;
        in_valid = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_out_kept", 64'(out_data[0]), 64'd90);
        window(2'd0, 5'd0, 18'd10, 18'd11, 18'd12);
        chk("clr_next_lane0", 64'(out_data[0]), 64'd90);
        chk("clr_next_lane1", 64'(out_data[1]), 64'd99);
        drain();

        // Coefficient write during ACCUM is dropped
        mode = 2'd0;
        send(18'd10, 18'd10, 18'd10);
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd2;
        for (int i = 0; i < TAPS - 1; i++)
            send(18'd10, 18'd10, 18'd10);
        coef_we = 1'b0;
        chk("guard_win", 64'(out_data[0]), 64'd90);
        drain();
        window(2'd0, 5'd0, 18'd10, 18'd10, 18'd10);
        chk("guard_next_win", 64'(out_data[0]), 64'd90);
        drain();

        // Write coinciding with tap-0 accept applies from the next window
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd2;
        send(18'd10, 18'd10, 18'd10);
        coef_we = 1'b0;
        for (int i = 0; i < TAPS - 1; i++)
            send(18'd10, 18'd10, 18'd10);
        chk("coinc_old_coef", 64'(out_data[0]), 64'd90);
        drain();
        window(2'd0, 5'd0, 18'd10, 18'd10, 18'd10);
        chk("coinc_new_coef", 64'(out_data[0]), 64'd100);
        drain();

        // Reserved mode behaves as MAC
        window(2'd3, 5'd0, 18'd10, 18'd1, 18'd0);
        chk("rsv_lane0", 64'(out_data[0]), 64'd100);
        chk("rsv_lane1", 64'(out_data[1]), 64'd10);
        drain();

        // Asynchronous reset while holding a result
        window(2'd0, 5'd0, 18'd10, 18'd10, 18'd10);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        window(2'd0, 5'd0, 18'd10, 18'd10, 18'd10);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_coefs_zero", 64'(out_data), 64'd0);
        drain();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/simd_filter_engine.md
# simd_filter_engine

Parametrised multi-lane image-filter execution engine for the filter GPU. It accepts a stream of TAPS pixel vectors, each LANES × DW bits, over a valid/ready handshake. For each lane it computes one of three results: a coefficient-weighted sum (scaled and saturated), a maximum, or a minimum. It emits one result vector per TAPS-sample window. It sits between the vector load path (the packed 3×18-bit read data) and the vector write-back path, generalising the fixed 3-lane, 18-bit datapath to arbitrary lane count, pixel width and kernel size.

## Interface
Parameters:
- LANES, 3, number of parallel pixel lanes
- DW, 18, pixel width per lane, unsigned
- TAPS, 9, samples per window (kernel size), ≥ 2
- CW, 8, coefficient width, signed two's complement

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort: return to IDLE and discard the window
- mode  in  2  0 = MAC, 1 = MAX, 2 = MIN, 3 = reserved (behaves as MAC)
- shift  in  5  right-shift applied to the MAC result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_data  in  CW  signed coefficient
- in_valid  in  1  input sample valid
- in_ready  out  1  engine accepts a sample this cycle
- in_data  in  [LANES-1:0][DW-1:0]  input pixel vector
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts the result
- out_data  out  [LANES-1:0][DW-1:0]  result vector
- busy  out  1  high in ACCUM or OUT

## Operation
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready = 1.
  - An accepted sample (in_valid & in_ready) is tap 0.
  - On that same edge, mode and shift are latched, the accumulators are initialised from tap 0, and the FSM goes to ACCUM with tap_cnt = 1.
- ACCUM:
  - in_ready = 1.
  - Each accepted sample updates the accumulators and increments tap_cnt.
  - The sample accepted with tap_cnt = TAPS−1 finalises the window, loads out_data and moves the FSM to OUT.
  - Gaps in in_valid are allowed; tap_cnt holds during gaps.
- OUT:
  - in_ready = 0 and out_valid = 1.
  - out_data is held stable until out_valid & out_ready, then the FSM returns to IDLE.
- MAC arithmetic, per lane:
  - Pixel is zero-extended to DW+1 bits signed, then multiplied by the signed coefficient indexed by tap.
  - Product width is DW+CW+1.
  - Accumulator width AW = DW+CW+1+$clog2(TAPS); it cannot overflow.
  - Result = acc >>> shift (arithmetic shift).
  - Clamp: result < 0 → 0; result > 2^DW−1 → 2^DW−1; otherwise the low DW bits.
- MAX/MIN: unsigned compare across all TAPS samples; coefficients and shift are ignored.
- Coefficients:
  - TAPS × CW register file, written when coef_we = 1 and the FSM is in IDLE.
  - Writes in ACCUM or OUT are dropped.
  - A write and a tap-0 accept in the same cycle: the sample uses the old coefficient; the new value applies from the next window.
  - coef_addr ≥ TAPS: the write is ignored.
- clr: highest priority after RST. From any state it goes to IDLE, clears out_valid and zeroes tap_cnt; out_data keeps its value. clr has priority over a simultaneous accept or output handshake.

## Timing
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, tap_cnt = 0, all coefficients = 0, accumulators = 0.
- Reset asserted mid-window: everything returns immediately to the reset values and no partial result is emitted.
- Latency: out_valid rises on the clock edge that accepts the last tap, i.e. it is visible 1 cycle after that sample is presented.
- Throughput: one window per TAPS+1 cycles at best, because the OUT handshake costs one cycle and in_ready is low in OUT.
- Handshake rules: once out_valid is high, it and out_data do not change until out_ready is high. in_data is sampled only when in_valid & in_ready.

## Structure
- Package filter_pkg:
  - mode_e enum (MODE_MAC, MODE_MAX, MODE_MIN, MODE_RSV).
  - state_e enum (IDLE, ACCUM, OUT).
  - Function for the clamp/saturate step.
- Sub-module filter_lane:
  - Contains one lane's multiply, accumulate, max/min and clamp.
  - Instantiated LANES times in a generate loop.
  - The top level owns the FSM, tap counter, coefficient file and handshakes.

## Test plan
All scenarios use the default parameters (LANES = 3, DW = 18, TAPS = 9, CW = 8).
- **Box filter:** coefficients all 1, shift 0, lanes fed 10 / 262143 / 0 for 9 samples → out_data = {10·9 = 90, 262143 saturated, 0}, out_valid 1 cycle after the 9th accept.
- **Negative clamp and shift:** coefficients all −1 with pixel 5 → 0. Coefficients all 1, shift 3, pixel 8 → 72 >>> 3 = 9.
- **MAX / MIN:** lane 0 sequence 3, 7, 1, 200, 9, 4, 4, 50, 2 → MAX gives 200, MIN gives 1; coefficients must have no effect.
- **Backpressure and gaps:**
  - in_valid dropped for 3 cycles mid-window → result is unchanged.
  - out_ready held low 5 cycles → out_valid and out_data stable, in_ready 0.
  - Handshake → in_ready 1 the next cycle.
- **Coefficient guard:** a write of coefficient 2 to index 0 during ACCUM is dropped, so the window uses the old value. A write in IDLE that coincides with a tap-0 accept takes effect from the next window only.
- **Abort and reset:**
  - clr after 4 taps → IDLE, no output; the next full window is correct.
  - RST low during OUT → out_valid 0 and out_data 0 immediately; coefficients 0 afterwards.
